pattern_buffer: RTL and testbench
=================================

# pattern_buffer

Multi-buffer field store between the packet ingress stream and the `pat` processor core.
- Ingress fields fill free buffers in arrival order.
- The processor reads fields by `fieldp`, writes result fields by `fieldwp` into the buffer it currently owns, then releases it.
- Released buffers stream out on the egress port and return to the free pool.

## Interface
Parameters:
- `buffer_width`, 8, field data width
- `fieldp_width`, 5, field index width (32 fields per buffer)
- `bufp_width`, 3, buffer index width (8 buffers)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- `in_data`  in  `buffer_width`  ingress field
- `in_valid`  in  1  ingress field present
- `in_last`  in  1  ingress field is the last of its pattern
- `in_ready`  out  1  ingress field accepted when `in_valid && in_ready`
- `fieldp`  in  `fieldp_width`  processor read index
- `field_in`  out  `buffer_width`  registered read data to processor
- `fieldwp`  in  `fieldp_width`  processor write index
- `field_out`  in  `buffer_width`  processor write data
- `field_we`  in  1  processor write strobe
- `proc_valid`  out  1  a filled buffer is owned by the processor
- `proc_done`  in  1  single-cycle release of the processor buffer
- `proc_bufp`  out  `bufp_width`  index of processor buffer (debug/status)
- `out_data`  out  `buffer_width`  egress field, 0 when `out_valid`=0
- `out_valid`  out  1  egress field present
- `out_last`  out  1  egress field is last of its buffer
- `out_ready`  in  1  egress field consumed when `out_valid && out_ready`
- `fill_level`  out  `bufp_width+1`  number of non-FREE buffers

## Operation
- **Buffer state:** per-buffer state FREE / FILLED / DONE, plus a length register of `fieldp_width+1` bits.
- **Pointers:** three circular pointers, each wrapping 7→0: `wr_buf` (ingress), `pr_buf` (processor), `rd_buf` (egress). Index counters `in_idx` and `out_idx`.
- **Ingress:**
  - `in_ready` = (state[`wr_buf`] == FREE).
  - On accept: mem[`wr_buf`][`in_idx`] ← `in_data`; `in_idx`++.
  - If `in_last` or `in_idx`==31: len ← `in_idx`+1, state ← FILLED, `wr_buf`++, `in_idx` ← 0. A 32-field pattern without `in_last` auto-closes; the next field starts a new buffer.
- **Processor:**
  - `proc_valid` = (state[`pr_buf`] == FILLED).
  - `field_in` ← mem[`pr_buf`][`fieldp`] every cycle, regardless of `proc_valid`.
  - `field_we` && `proc_valid`: mem[`pr_buf`][`fieldwp`] ← `field_out`. Any index 0..31 is writable; len is unchanged. `field_we` without `proc_valid` is ignored.
  - `proc_done` && `proc_valid`: state ← DONE, `pr_buf`++. `proc_done` without `proc_valid` is ignored.
- **Egress:**
  - `out_valid` = (state[`rd_buf`] == DONE).
  - `out_data` = mem[`rd_buf`][`out_idx`] (combinational read).
  - `out_last` = `out_valid` && (`out_idx` == len−1).
  - On accept: `out_idx`++. On the last accept: state ← FREE, `rd_buf`++, `out_idx` ← 0.
- **Ordering:** buffers are FIFO end to end. Pointers never overtake because the state gates each stage.
- **Fill level:** `fill_level` counts FILLED + DONE buffers. Ingress close and egress free in the same cycle leave it unchanged.

## Timing
- **Reset values:**
  - All states FREE; all pointers and indices 0.
  - `in_ready`=1, `proc_valid`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `field_in`=0, `fill_level`=0, `proc_bufp`=0.
  - Memory contents are not cleared.
- **Reset mid-operation:** a partially received ingress pattern and all queued buffers are discarded.
- **Read latency:** `field_in` has 1-cycle latency from `fieldp`.
- **Read/write collision:** when `field_we` targets `fieldwp`==`fieldp` in the same cycle, `field_in` returns the pre-write value. The new value is visible on the following read.
- **Handoff latency:**
  - A buffer closed at edge N gives `proc_valid`=1 after edge N, provided it is at `pr_buf`.
  - `proc_done` at edge N gives `out_valid` after edge N, provided the buffer is at `rd_buf`.
- **Full:** with all 8 buffers non-FREE, `in_ready`=0.
- **Freed buffer reuse:** a buffer freed by egress at edge N raises `in_ready` after edge N. `in_ready` never uses same-cycle bypass.
- **Ingress vs. processor write:** ingress and processor writes target different buffers by construction, so there is no write conflict.

## Structure
- **Package `pat_buf_pkg`:** `buf_state_t` enum (FREE, FILLED, DONE) and the default width constants. These are shared with `pat` parameters.
- **Sub-module `pattern_field_ram`:** flop array of `2^bufp_width × 2^fieldp_width × buffer_width` with:
  - two write ports (ingress, processor);
  - one registered read port (processor);
  - one combinational read port (egress).
- **Top level:** pointers, state vector, lengths and handshake logic.

## Test plan
- **Single pattern:** after reset, ingress 3 fields 0x11,0x22,0x33 (`in_last` on 0x33) → `proc_valid` next cycle; `fieldp`=1 gives `field_in`=0x22 one cycle later.
- **Write-then-egress:** processor writes 0xAA at `fieldwp`=2, pulses `proc_done` → egress 0x11,0x22,0xAA, `out_last` on the 3rd field, then `fill_level`=0.
- **Full:** fill 8 patterns, processor idle → `in_ready`=0 and `fill_level`=8. Drain one through processor and egress → `in_ready`=1 the cycle after the last egress accept.
- **Auto-close:** 33 ingress fields without `in_last` → buffer 0 has len=32; field 33 lands in buffer 1 index 0.
- **Collision:** `fieldp`=`fieldwp`=4, old value 0x05, write 0x77 → `field_in`=0x05, then 0x77 on the next read. `proc_done` while `proc_valid`=0 → no state change.
- **Async reset mid-stream:** assert `reset` mid-ingress and mid-egress (asynchronous, between edges) → outputs immediately at reset values; no egress of stale buffers afterward.

Source files
------------

// File: rtl/pat_buf_pkg.sv
// Shared types and default widths for the pattern buffer and the pat core.
package pat_buf_pkg;

    localparam int BUFFER_WIDTH = 8;
    localparam int FIELDP_WIDTH = 5;
    localparam int BUFP_WIDTH   = 3;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        FILLED = 2'd1,
        DONE   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pattern_field_ram.sv
// Flop-array field store: two write ports, one registered and one combinational read port.
module pattern_field_ram
    import pat_buf_pkg::*;
#(
    parameter int buffer_width = BUFFER_WIDTH,
    parameter int fieldp_width = FIELDP_WIDTH,
    parameter int bufp_width   = BUFP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iw_en_i,
    input  logic [bufp_width-1:0]   iw_buf_i,
    input  logic [fieldp_width-1:0] iw_idx_i,
    input  logic [buffer_width-1:0] iw_data_i,
    input  logic                    pw_en_i,
    input  logic [bufp_width-1:0]   pw_buf_i,
    input  logic [fieldp_width-1:0] pw_idx_i,
    input  logic [buffer_width-1:0] pw_data_i,
    input  logic [bufp_width-1:0]   pr_buf_i,
    input  logic [fieldp_width-1:0] pr_idx_i,
    output logic [buffer_width-1:0] pr_data_o,
    input  logic [bufp_width-1:0]   er_buf_i,
    input  logic [fieldp_width-1:0] er_idx_i,
    output logic [buffer_width-1:0] er_data_o
);

    localparam int DEPTH = 1 << (bufp_width + fieldp_width);

    logic [buffer_width-1:0] mem_q [DEPTH];
    logic [buffer_width-1:0] pr_data_q;

    // Storage writes; the two ports never hit the same buffer, so order is irrelevant.
    always_ff @(posedge clk) begin
        if (iw_en_i) begin
            mem_q[{iw_buf_i, iw_idx_i}] <= iw_data_i;
        end
        if (pw_en_i) begin
            mem_q[{pw_buf_i, pw_idx_i}] <= pw_data_i;
        end
    end

    // Registered processor read; returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_data_q <= {buffer_width{1'b0}};
        end else begin
            pr_data_q <= mem_q[{pr_buf_i, pr_idx_i}];
        end
    end

    assign pr_data_o = pr_data_q;
    assign er_data_o = mem_q[{er_buf_i, er_idx_i}];

endmodule

// File: rtl/pattern_buffer.sv
// Multi-buffer field store: ingress fills, processor edits and releases, egress drains, FIFO order.
module pattern_buffer
    import pat_buf_pkg::*;
#(
    parameter int buffer_width = BUFFER_WIDTH,
    parameter int fieldp_width = FIELDP_WIDTH,
    parameter int bufp_width   = BUFP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic [fieldp_width-1:0] fieldp,
    output logic [buffer_width-1:0] field_in,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_we,
    output logic                    proc_valid,
    input  logic                    proc_done,
    output logic [bufp_width-1:0]   proc_bufp,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [bufp_width:0]     fill_level
);

    localparam int NUM_BUF = 1 << bufp_width;
    localparam int LEN_W   = fieldp_width + 1;
    localparam logic [bufp_width-1:0]   BUF_INC = bufp_width'(1);
    localparam logic [fieldp_width-1:0] IDX_INC = fieldp_width'(1);
    localparam logic [LEN_W-1:0]        LEN_INC = LEN_W'(1);
    localparam logic [bufp_width:0]     FILL_INC = (bufp_width + 1)'(1);

    buf_state_t              state_q [NUM_BUF];
    buf_state_t              state_d [NUM_BUF];
    logic [LEN_W-1:0]        len_q   [NUM_BUF];
    logic [LEN_W-1:0]        len_d   [NUM_BUF];
    logic [bufp_width-1:0]   wr_buf_q, wr_buf_d, pr_buf_q, pr_buf_d, rd_buf_q, rd_buf_d;
    logic [fieldp_width-1:0] in_idx_q, in_idx_d, out_idx_q, out_idx_d;
    logic [bufp_width:0]     fill_q, fill_d;

    logic                    in_acc_s, in_close_s, proc_wr_s, proc_rel_s, out_acc_s, out_free_s;
    logic [buffer_width-1:0] er_data_s;

    assign in_ready   = (state_q[wr_buf_q] == FREE);
    assign proc_valid = (state_q[pr_buf_q] == FILLED);
    assign out_valid  = (state_q[rd_buf_q] == DONE);
    assign out_last   = out_valid && ({1'b0, out_idx_q} == (len_q[rd_buf_q] - LEN_INC));
    assign out_data   = out_valid ? er_data_s : {buffer_width{1'b0}};
    assign proc_bufp  = pr_buf_q;
    assign fill_level = fill_q;

    assign in_acc_s   = in_valid && in_ready;
    assign in_close_s = in_acc_s && (in_last || (&in_idx_q));
    assign proc_wr_s  = field_we && proc_valid;
    assign proc_rel_s = proc_done && proc_valid;
    assign out_acc_s  = out_valid && out_ready;
    assign out_free_s = out_acc_s && out_last;

    pattern_field_ram #(
        .buffer_width (buffer_width),
        .fieldp_width (fieldp_width),
        .bufp_width   (bufp_width)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .iw_en_i   (in_acc_s),
        .iw_buf_i  (wr_buf_q),
        .iw_idx_i  (in_idx_q),
        .iw_data_i (in_data),
        .pw_en_i   (proc_wr_s),
        .pw_buf_i  (pr_buf_q),
        .pw_idx_i  (fieldwp),
        .pw_data_i (field_out),
        .pr_buf_i  (pr_buf_q),
        .pr_idx_i  (fieldp),
        .pr_data_o (field_in),
        .er_buf_i  (rd_buf_q),
        .er_idx_i  (out_idx_q),
        .er_data_o (er_data_s)
    );

    // Next-state for buffer states, lengths, pointers and indices; the three stages touch distinct buffers.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_buf_d  = wr_buf_q;
        pr_buf_d  = pr_buf_q;
        rd_buf_d  = rd_buf_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        fill_d    = fill_q;

        if (in_close_s) begin
            state_d[wr_buf_q] = FILLED;
            len_d[wr_buf_q]   = {1'b0, in_idx_q} + LEN_INC;
            wr_buf_d          = wr_buf_q + BUF_INC;
            in_idx_d          = {fieldp_width{1'b0}};
        end else if (in_acc_s) begin
            in_idx_d = in_idx_q + IDX_INC;
        end else begin
            in_idx_d = in_idx_q;
        end

        if (proc_rel_s) begin
            state_d[pr_buf_q] = DONE;
            pr_buf_d          = pr_buf_q + BUF_INC;
        end else begin
            pr_buf_d = pr_buf_q;
        end

        if (out_free_s) begin
            state_d[rd_buf_q] = FREE;
            rd_buf_d          = rd_buf_q + BUF_INC;
            out_idx_d         = {fieldp_width{1'b0}};
        end else if (out_acc_s) begin
            out_idx_d = out_idx_q + IDX_INC;
        end else begin
            out_idx_d = out_idx_q;
        end

        case ({in_close_s, out_free_s})
            2'b10:   fill_d = fill_q + FILL_INC;
            2'b01:   fill_d = fill_q - FILL_INC;
            default: fill_d = fill_q;
        endcase
    end

    // Control state register; memory contents are deliberately left uncleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                state_q[b] <= FREE;
                len_q[b]   <= {LEN_W{1'b0}};
            end
            wr_buf_q  <= {bufp_width{1'b0}};
            pr_buf_q  <= {bufp_width{1'b0}};
            rd_buf_q  <= {bufp_width{1'b0}};
            in_idx_q  <= {fieldp_width{1'b0}};
            out_idx_q <= {fieldp_width{1'b0}};
            fill_q    <= {(bufp_width + 1){1'b0}};
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_buf_q  <= wr_buf_d;
            pr_buf_q  <= pr_buf_d;
            rd_buf_q  <= rd_buf_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: tb/tb_pattern_buffer.sv
// Self-checking bench for pattern_buffer: directed scenarios plus random traffic against a queue-level model.
module tb_pattern_buffer;

    localparam int NB = 8;
    localparam int NF = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [4:0] fieldp, fieldwp;
    logic [7:0] field_in, field_out;
    logic       field_we, proc_valid, proc_done;
    logic [2:0] proc_bufp;
    logic [7:0] out_data;
    logic       out_valid, out_last, out_ready;
    logic [3:0] fill_level;

    always #5 clk = ~clk;

    pattern_buffer dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .fieldp(fieldp), .field_in(field_in),
        .fieldwp(fieldwp), .field_out(field_out), .field_we(field_we),
        .proc_valid(proc_valid), .proc_done(proc_done), .proc_bufp(proc_bufp),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .fill_level(fill_level)
    );

    int checks = 0;
    int errors = 0;

    // Model: buffers form a FIFO ring starting at m_rd: n_done released, then n_filled awaiting the core.
    logic [7:0] mem_m   [NB][NF];
    bit         known_m [NB][NF];
    int         len_m   [NB];
    int         m_rd, n_filled, n_done, m_in_idx, m_out_idx;
    logic [7:0] fi_exp;
    bit         fi_known;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; n_filled = 0; n_done = 0; m_in_idx = 0; m_out_idx = 0;
        fi_exp = 8'h00; fi_known = 1'b1;
    endtask

    task automatic compare_all();
        int nonfree = n_filled + n_done;
        bit ov = (n_done > 0);
        chk("in_ready", int'(in_ready), int'(nonfree < NB));
        chk("proc_valid", int'(proc_valid), int'(n_filled > 0));
        chk("proc_bufp", int'(proc_bufp), (m_rd + n_done) % NB);
        chk("out_valid", int'(out_valid), int'(ov));
        chk("out_data", int'(out_data), ov ? int'(mem_m[m_rd][m_out_idx]) : 0);
        chk("out_last", int'(out_last), int'(ov && (m_out_idx == len_m[m_rd] - 1)));
        chk("fill_level", int'(fill_level), nonfree);
        if (fi_known) chk("field_in", int'(field_in), int'(fi_exp));
    endtask

    task automatic model_update();
        int nonfree = n_filled + n_done;
        int wr = (m_rd + nonfree) % NB;
        int pr = (m_rd + n_done) % NB;
        bit ir = (nonfree < NB);
        bit pv = (n_filled > 0);
        bit ov = (n_done > 0);
        int close = 0, rel = 0, freed = 0;
        fi_exp   = mem_m[pr][fieldp];
        fi_known = known_m[pr][fieldp];
        if (in_valid && ir) begin
            mem_m[wr][m_in_idx] = in_data;
            known_m[wr][m_in_idx] = 1'b1;
            if (in_last || m_in_idx == NF - 1) begin
                len_m[wr] = m_in_idx + 1;
                close = 1;
                m_in_idx = 0;
            end else begin
                m_in_idx++;
            end
        end
        if (field_we && pv) begin
            mem_m[pr][fieldwp] = field_out;
            known_m[pr][fieldwp] = 1'b1;
        end
        if (proc_done && pv) rel = 1;
        if (out_ready && ov) begin
            if (m_out_idx == len_m[m_rd] - 1) begin
                freed = 1;
                m_out_idx = 0;
            end else begin
                m_out_idx++;
            end
        end
        n_filled += close - rel;
        n_done   += rel - freed;
        if (freed != 0) m_rd = (m_rd + 1) % NB;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        fieldp = 5'd0; fieldwp = 5'd0; field_out = 8'h00;
        field_we = 1'b0; proc_done = 1'b0; out_ready = 1'b0;
    endtask

    // Called at a falling edge; reset is raised between edges and must act at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_in_ready", int'(in_ready), 1);
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_data", int'(out_data), 0);
        chk("async_rst_proc_valid", int'(proc_valid), 0);
        chk("async_rst_fill", int'(fill_level), 0);
        chk("async_rst_field_in", int'(field_in), 0);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        in_valid = 1'b1; in_data = d; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        int beats;
        bit last_seen;
        for (int b = 0; b < NB; b++)
            for (int f = 0; f < NF; f++) known_m[b][f] = 1'b0;
        for (int b = 0; b < NB; b++) len_m[b] = 1;
        idle();
        reset = 1'b0;
        model_reset();
        fi_known = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_proc_bufp", int'(proc_bufp), 0);
        chk("rst_out_last", int'(out_last), 0);

        // Single pattern and registered read
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        chk("single_proc_valid", int'(proc_valid), 1);
        fieldp = 5'd1;
        tick();
        chk("single_field_in", int'(field_in), 8'h22);

        // Processor write then egress
        fieldwp = 5'd2; field_out = 8'hAA; field_we = 1'b1;
        tick();
        field_we = 1'b0; proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk("egr_valid", int'(out_valid), 1);
        chk("egr_d0", int'(out_data), 8'h11);
        chk("egr_last0", int'(out_last), 0);
        out_ready = 1'b1;
        tick();
        chk("egr_d1", int'(out_data), 8'h22);
        tick();
        chk("egr_d2", int'(out_data), 8'hAA);
        chk("egr_last2", int'(out_last), 1);
        tick();
        out_ready = 1'b0;
        chk("egr_fill0", int'(fill_level), 0);

        // Full pool, then free one buffer
        for (int i = 0; i < NB; i++) send(8'h40 + 8'(i), 1'b1);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_fill", int'(fill_level), 8);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk("full_still_blocked", int'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_reuse_ready", int'(in_ready), 1);
        chk("full_fill7", int'(fill_level), 7);

        // Auto-close at 32 fields
        do_reset();
        for (int i = 0; i < 33; i++) send(8'h80 + 8'(i), 1'b0);
        chk("auto_fill", int'(fill_level), 1);
        chk("auto_proc_valid", int'(proc_valid), 1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        chk("auto_bufp", int'(proc_bufp), 1);
        fieldp = 5'd0;
        tick();
        chk("auto_field33", int'(field_in), 8'hA0);
        out_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            if (!out_valid) break;
            beats++;
            last_seen = out_last;
            tick();
            if (last_seen) break;
        end
        out_ready = 1'b0;
        chk("auto_len", beats, 32);

        // Read/write collision and ignored release
        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
        fieldp = 5'd4; fieldwp = 5'd4; field_out = 8'h77; field_we = 1'b1;
        tick();
        field_we = 1'b0;
        chk("coll_old", int'(field_in), 8'h05);
        tick();
        chk("coll_new", int'(field_in), 8'h77);
        proc_done = 1'b1;
        tick();
        tick();
        proc_done = 1'b0;
        chk("idle_done_bufp", int'(proc_bufp), 1);
        chk("idle_done_fill", int'(fill_level), 1);

        // Reset in the middle of ingress and egress
        do_reset();
        for (int p = 0; p < 2; p++) begin
            send(8'hC0, 1'b0); send(8'hC1, 1'b0); send(8'hC2, 1'b1);
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        out_ready = 1'b1;
        tick();
        send(8'hEE, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_egress", int'(out_valid), 0);
        end
        idle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_last   = ($urandom_range(0, 5) == 0);
            in_data   = 8'($urandom);
            fieldp    = 5'($urandom);
            fieldwp   = 5'($urandom);
            field_out = 8'($urandom);
            field_we  = ($urandom_range(0, 9) < 3);
            proc_done = ($urandom_range(0, 19) < 3);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
